// File: rtl/pixel_stream_proc.sv
// Per-pixel stream stage: bypass / invert / threshold / 3-tap smoothing with a
// per-line mode latch, a 2-entry output FIFO and a completed-line counter.
module pixel_stream_proc #(
  parameter int PIXEL_W  = 8,
  parameter int LINE_LEN = 64,
  parameter int LCNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] thresh,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_eol,
  output logic [LCNT_W-1:0]  line_count
);

  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

  typedef struct packed {
    logic [PIXEL_W-1:0] pix;
    logic               eol;
  } ent_t;

  ent_t               mem_q [2];
  ent_t               mem_d [2];
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [1:0]         mode_q, mode_d;
  logic [PIXEL_W-1:0] h1_q, h1_d, h2_q, h2_d;
  logic [LCNT_W-1:0]  lcnt_q, lcnt_d;

  logic               accept, pop, col0, last;
  logic [1:0]         eff_mode;
  logic [PIXEL_W-1:0] h1e, h2e, res;
  logic [PIXEL_W+1:0] sum;

  assign in_ready   = !rst && (cnt_q != 2'd2);
  assign out_valid  = (cnt_q != 2'd0);
  assign out_pixel  = mem_q[rd_q].pix;
  assign out_eol    = mem_q[rd_q].eol;
  assign line_count = lcnt_q;

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign col0     = (col_q == '0);
  assign last     = (col_q == COL_LAST);
  // The first pixel of a line sees the live mode; the rest use the latched one.
  assign eff_mode = col0 ? mode : mode_q;

  // Edge replication at the start of a line keeps the previous line out of the taps.
  assign h1e = col0 ? in_pixel : h1_q;
  assign h2e = col0 ? in_pixel : ((col_q == COL_W'(1)) ? h1_q : h2_q);
  assign sum = {2'b00, h2e} + {1'b0, h1e, 1'b0} + {2'b00, in_pixel};

  always_comb begin
    res = in_pixel;
    case (eff_mode)
      2'd0: res = in_pixel;
      2'd1: res = ~in_pixel;
      2'd2: res = (in_pixel >= thresh) ? {PIXEL_W{1'b1}} : '0;
      2'd3: res = sum[PIXEL_W+1:2];
      default: res = in_pixel;
    endcase
  end

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    col_d  = col_q;
    mode_d = mode_q;
    h1_d   = h1_q;
    h2_d   = h2_q;
    lcnt_d = lcnt_q;
    cnt_d  = cnt_q + {1'b0, accept} - {1'b0, pop};
    if (accept) begin
      mem_d[wr_q] = '{pix: res, eol: last};
      wr_d        = ~wr_q;
      col_d       = last ? '0 : col_q + COL_W'(1);
      h1_d        = in_pixel;
      h2_d        = h1_q;
      if (col0) mode_d = mode;
    end
    if (pop) begin
      rd_d = ~rd_q;
      if (mem_q[rd_q].eol) lcnt_d = lcnt_q + LCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
      col_q    <= '0;
      mode_q   <= 2'd0;
      h1_q     <= '0;
      h2_q     <= '0;
      lcnt_q   <= '0;
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      col_q  <= col_d;
      mode_q <= mode_d;
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      lcnt_q <= lcnt_d;
    end
  end

endmodule
